// File: rtl/vec_stream_pkg.sv
// ---------------------------------------------------------------------------
// vec_stream_pkg
// Shared types and helpers for the vector stream concatenate/split blocks.
//   split_state_t : split2 controller state (FILL collects one vector,
//                   DRAIN hands it out on the two output lanes)
//   ptr_width()   : width of an element-counting pointer for a vector of
//                   'total' elements ($clog2(total)+1, so the pointer can
//                   also represent the value 'total' without wrapping)
// ---------------------------------------------------------------------------
package vec_stream_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } split_state_t;

    function automatic int ptr_width(input int total);
        return $clog2(total) + 1;
    endfunction

endpackage : vec_stream_pkg

// File: rtl/split_drain_lane.sv
// ---------------------------------------------------------------------------
// split_drain_lane
// One output lane of split2. Walks the lane's region of the shared vector
// buffer [Base, Base+Elements) in steps of PerRead elements and presents
// each step as a valid/ready beat. Once the last beat has been taken the
// lane raises done_o and stays quiet until the top level clears it.
//
// Ports
//   clk_in    in   clock, rising edge
//   rst_in    in   asynchronous active-low reset
//   active_i  in   top level is draining (buffer holds a complete vector)
//   clear_i   in   vector finished on both lanes: drop the done flag
//   buf_i     in   whole vector buffer, element e in [e*NBits +: NBits]
//   ready_i   in   lane consumer accepts the beat
//   valid_o   out  lane beat available
//   data_o    out  PerRead elements starting at Base+rd_ptr
//   done_o    out  this lane has delivered its full region
// ---------------------------------------------------------------------------
module split_drain_lane
    import vec_stream_pkg::*;
#(
    parameter int NBits    = 8,
    parameter int Total    = 6,
    parameter int Base     = 0,
    parameter int Elements = 4,
    parameter int PerRead  = 2,
    parameter int PtrW     = ptr_width(Total)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     active_i,
    input  logic                     clear_i,
    input  logic [Total*NBits-1:0]   buf_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [PerRead*NBits-1:0] data_o,
    output logic                     done_o
);

    localparam logic [PtrW-1:0] STEP      = PtrW'(PerRead);
    localparam logic [PtrW-1:0] LAST_BEAT = PtrW'(Elements - PerRead);

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d;
    logic            fire;
    int              rd_base;

    assign valid_o = active_i && !done_q;
    assign fire    = valid_o && ready_i;
    assign done_o  = done_q;

    // Data is a pure function of registered state, so it cannot move while
    // the consumer stalls a beat.
    assign rd_base = Base + int'(rd_ptr_q);
    assign data_o  = buf_i[rd_base*NBits +: PerRead*NBits];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        done_d   = done_q;
        if (fire) begin
            if (rd_ptr_q == LAST_BEAT) begin
                rd_ptr_d = '0;
                done_d   = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q + STEP;
            end
        end
        // clear_i is only raised once both lanes are done, so it can never
        // coincide with a handshake on this lane.
        if (clear_i) begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
        end
    end

endmodule : split_drain_lane

// File: rtl/split2.sv
// ---------------------------------------------------------------------------
// split2
// De-concatenates one vector stream into two. A full vector of
// VecElements0+VecElements1 elements is collected ElementsPerWrite at a time,
// then elements [0, VecElements0) leave on lane 0 and the rest on lane 1,
// each lane at its own beat width and at its own pace. When both lanes have
// drained, vec_done pulses and the block goes back to collecting.
//
// Ports
//   clk_in      in   clock, rising edge
//   rst_in      in   asynchronous active-low reset
//   in_valid    in   input beat offered
//   in_data     in   ElementsPerWrite elements, element k in [k*NBits +: NBits]
//   in_ready    out  block accepts an input beat (FILL only)
//   out0_valid  out  lane-0 beat available
//   out0_ready  in   lane-0 consumer takes the beat
//   out0_data   out  ElementsPerRead0 elements, same packing as in_data
//   out1_valid  out  lane-1 beat available
//   out1_ready  in   lane-1 consumer takes the beat
//   out1_data   out  ElementsPerRead1 elements, same packing as in_data
//   vec_done    out  one-cycle pulse when both lanes finished a vector
// ---------------------------------------------------------------------------
module split2
    import vec_stream_pkg::*;
#(
    parameter int NBits            = 8,
    parameter int VecElements0     = 4,
    parameter int VecElements1     = 2,
    parameter int ElementsPerWrite = 2,
    parameter int ElementsPerRead0 = 2,
    parameter int ElementsPerRead1 = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              in_valid,
    input  logic [ElementsPerWrite*NBits-1:0] in_data,
    output logic                              in_ready,
    output logic                              out0_valid,
    input  logic                              out0_ready,
    output logic [ElementsPerRead0*NBits-1:0] out0_data,
    output logic                              out1_valid,
    input  logic                              out1_ready,
    output logic [ElementsPerRead1*NBits-1:0] out1_data,
    output logic                              vec_done
);

    localparam int TOTAL = VecElements0 + VecElements1;
    localparam int PW    = ptr_width(TOTAL);

    localparam logic [PW-1:0] WR_STEP = PW'(ElementsPerWrite);
    localparam logic [PW-1:0] WR_LAST = PW'(TOTAL - ElementsPerWrite);

    // ------------------------------------------------------------------
    // Parameter sanity: every beat width must tile its region exactly.
    // ------------------------------------------------------------------
    if (TOTAL % ElementsPerWrite != 0) begin : g_bad_write_width
        $error("split2: ElementsPerWrite must divide VecElements0+VecElements1");
    end
    if (VecElements0 % ElementsPerRead0 != 0) begin : g_bad_read0_width
        $error("split2: ElementsPerRead0 must divide VecElements0");
    end
    if (VecElements1 % ElementsPerRead1 != 0) begin : g_bad_read1_width
        $error("split2: ElementsPerRead1 must divide VecElements1");
    end

    split_state_t          state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  run_q;
    logic                  in_fire;
    logic                  draining;
    logic                  done0, done1;
    logic [TOTAL*NBits-1:0] buf_flat;

    // run_q holds in_ready low for the whole reset period and the cycle in
    // which reset is released; it rises at the first clock edge afterwards.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign draining = (state_q == DRAIN);
    assign in_ready = run_q && (state_q == FILL);
    assign in_fire  = in_valid && in_ready;
    // Done flags are only ever set while draining, but qualify anyway so the
    // pulse cannot appear in FILL.
    assign vec_done = draining && done0 && done1;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        unique case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (wr_ptr_q == WR_LAST) begin
                        wr_ptr_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_ptr_d = wr_ptr_q + WR_STEP;
                    end
                end
            end
            DRAIN: begin
                if (vec_done) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d  = FILL;
                wr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= FILL;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Vector buffer: one register per element. Each element decides on its
    // own whether the current input beat covers it, which keeps the write
    // path a small per-element mux instead of a shifted wide store.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < TOTAL; gi++) begin : g_elem
        logic             hit;
        logic [NBits-1:0] wdata;
        logic [NBits-1:0] elem_q;

        always_comb begin
            hit   = 1'b0;
            wdata = '0;
            for (int k = 0; k < ElementsPerWrite; k++) begin
                if (int'(wr_ptr_q) + k == gi) begin
                    hit   = 1'b1;
                    wdata = in_data[k*NBits +: NBits];
                end
            end
        end

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                elem_q <= '0;
            end else if (in_fire && hit) begin
                elem_q <= wdata;
            end
        end

        assign buf_flat[gi*NBits +: NBits] = elem_q;
    end

    // ------------------------------------------------------------------
    // Output lanes
    // ------------------------------------------------------------------
    split_drain_lane #(
        .NBits    (NBits),
        .Total    (TOTAL),
        .Base     (0),
        .Elements (VecElements0),
        .PerRead  (ElementsPerRead0),
        .PtrW     (PW)
    ) u_lane0 (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .active_i (draining),
        .clear_i  (vec_done),
        .buf_i    (buf_flat),
        .ready_i  (out0_ready),
        .valid_o  (out0_valid),
        .data_o   (out0_data),
        .done_o   (done0)
    );

    split_drain_lane #(
        .NBits    (NBits),
        .Total    (TOTAL),
        .Base     (VecElements0),
        .Elements (VecElements1),
        .PerRead  (ElementsPerRead1),
        .PtrW     (PW)
    ) u_lane1 (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .active_i (draining),
        .clear_i  (vec_done),
        .buf_i    (buf_flat),
        .ready_i  (out1_ready),
        .valid_o  (out1_valid),
        .data_o   (out1_data),
        .done_o   (done1)
    );

endmodule : split2
